// File: rtl/cpu_writeback_arbiter.sv
// cpu_writeback_arbiter
//   Merges ALU results and load responses onto the single register file write
//   port and tracks which registers still wait on a load (decode hazards).
//
//   Load handshakes:
//   - An issue is accepted on i_ld_issue && o_ld_issue_ready.
//   - A response is accepted on i_ld_valid && o_ld_ready.
//   - The ALU path is never back-pressured.
//
// Ports
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_alu_valid/i_alu_rd/i_alu_data    ALU result
//   i_ld_issue/i_ld_rd/o_ld_issue_ready load issue, tag FIFO not full
//   i_ld_valid/i_ld_data/o_ld_ready    in-order load response
//   i_rs1_addr/i_rs2_addr/i_rd_addr    hazard query; o_stall result
//   o_wr_en/o_wr_addr/o_wr_data        registered register file write
//   o_addr_oob                         out-of-bounds address (half regfile)
//   o_ld_unexp                         response with no load outstanding
module cpu_writeback_arbiter #(
    parameter bit p_half_regfile = 1'b0,
    parameter int p_ld_depth     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_rd,
    output logic        o_ld_issue_ready,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [4:0]  i_rd_addr,
    output logic        o_stall,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_addr_oob,
    output logic        o_ld_unexp
);

    localparam int PW = (p_ld_depth > 1) ? $clog2(p_ld_depth) : 1;
    localparam int CW = $clog2(p_ld_depth + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(p_ld_depth - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(p_ld_depth);

    logic [4:0]    tag_q [p_ld_depth];
    logic [4:0]    tag_d [p_ld_depth];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_valid_q, hold_valid_d;
    logic [4:0]    hold_rd_q, hold_rd_d;
    logic [31:0]   hold_data_q, hold_data_d;
    logic [31:0]   pending_q, pending_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          wr_is_ld_q, wr_is_ld_d;
    logic          ld_unexp_q, ld_unexp_d;

    logic fifo_empty, fifo_full, alu_oob, issue_oob;
    logic issue_acc, resp_acc, alu_claim;
    logic [4:0] head_rd;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == FULL_CNT);
        alu_oob    = p_half_regfile && i_alu_rd[4];
        issue_oob  = p_half_regfile && i_ld_rd[4];
        o_addr_oob = p_half_regfile &&
                     ((i_alu_valid && i_alu_rd[4]) || (i_ld_issue && i_ld_rd[4]) ||
                      i_rs1_addr[4] || i_rs2_addr[4] || i_rd_addr[4]);
        o_ld_issue_ready = !fifo_full;
        o_ld_ready       = !hold_valid_q && !fifo_empty;
        issue_acc = i_ld_issue && !fifo_full && !issue_oob;
        resp_acc  = i_ld_valid && o_ld_ready;
        // An ALU result to x0 never needs the port, so it does not block loads.
        alu_claim = i_alu_valid && !alu_oob && (i_alu_rd != 5'd0);
        head_rd   = tag_q[rd_ptr_q];
        o_stall   = ((i_rs1_addr != 5'd0) && pending_q[i_rs1_addr]) ||
                    ((i_rs2_addr != 5'd0) && pending_q[i_rs2_addr]) ||
                    ((i_rd_addr  != 5'd0) && pending_q[i_rd_addr]);
    end

    always_comb begin
        tag_d        = tag_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        pending_d    = pending_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_is_ld_d   = 1'b0;
        ld_unexp_d   = i_ld_valid && fifo_empty;

        if (resp_acc) rd_ptr_d = ptr_next(rd_ptr_q);
        if (issue_acc) begin
            tag_d[wr_ptr_q] = i_ld_rd;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        case ({issue_acc, resp_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Fixed priority: ALU, held load, bypassing load.
        if (alu_claim) begin
            wr_en_d   = 1'b1;
            wr_addr_d = i_alu_rd;
            wr_data_d = i_alu_data;
            if (resp_acc) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = head_rd;
                hold_data_d  = i_ld_data;
            end
        end else if (hold_valid_q) begin
            hold_valid_d = 1'b0;
            wr_en_d      = (hold_rd_q != 5'd0);
            wr_addr_d    = hold_rd_q;
            wr_data_d    = hold_data_q;
            wr_is_ld_d   = 1'b1;
        end else if (resp_acc) begin
            wr_en_d    = (head_rd != 5'd0);
            wr_addr_d  = head_rd;
            wr_data_d  = i_ld_data;
            wr_is_ld_d = 1'b1;
        end

        // Clear first so a same-edge set of the same register wins.
        if (wr_en_q && wr_is_ld_q) pending_d[wr_addr_q] = 1'b0;
        if (issue_acc && (i_ld_rd != 5'd0)) pending_d[i_ld_rd] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        tag_q <= tag_d;
        if (i_rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            pending_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_is_ld_q   <= 1'b0;
            ld_unexp_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            pending_q    <= pending_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_is_ld_q   <= wr_is_ld_d;
            ld_unexp_q   <= ld_unexp_d;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_ld_unexp = ld_unexp_q;

endmodule

// File: doc/cpu_writeback_arbiter.md
CPU_WRITEBACK_ARBITER -- requirements
Module: cpu_writeback_arbiter

Interface
REQ-001 SHALL have parameter p_half_regfile, default 0, meaning: 16 registers; any address with bit 4 set is out of bounds.
REQ-002 SHALL have parameter p_ld_depth, default 2, meaning: maximum outstanding loads (1..4).
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  global clock; single clock domain
- i_rst  in  1  global reset; synchronous, active-high
- i_alu_valid  in  1  ALU result valid this cycle; never back-pressured
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  32  ALU result
- i_ld_issue  in  1  load issued this cycle
- i_ld_rd  in  5  issued load destination
- o_ld_issue_ready  out  1  a tag slot is free
- i_ld_valid  in  1  load response valid
- i_ld_data  in  32  load response data
- o_ld_ready  out  1  load response accepted this cycle
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  5 each  decode-stage hazard query
- o_stall  out  1  hazard on a pending load destination
- o_wr_en  out  1  register file write enable
- o_wr_addr  out  5  register file write address
- o_wr_data  out  32  register file write data
- o_addr_oob  out  1  out-of-bounds address seen this cycle
- o_ld_unexp  out  1  response arrived with no load outstanding

Function
REQ-004 SHALL keep an in-order tag FIFO of depth p_ld_depth holding issued load rd values; o_ld_issue_ready = not full.
REQ-005 SHALL push i_ld_rd on i_ld_issue && o_ld_issue_ready; SHALL ignore an issue when full.
REQ-006 SHALL pair each accepted load response with the head tag and pop the tag on acceptance; responses return in issue order.
REQ-007 SHALL hold one load response in a hold register; o_ld_ready = !hold_valid && tag FIFO non-empty.
REQ-008 SHALL give the write port fixed priority per cycle: ALU result, then held load, then an incoming load bypassing the hold register.
REQ-009 SHALL place a load response in the hold register when i_alu_valid wins the same cycle.
REQ-010 SHALL register o_wr_en/o_wr_addr/o_wr_data: a write selected in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
REQ-011 SHALL drop writes with rd = 0 (o_wr_en stays 0); a load to x0 still consumes its tag and response.
REQ-012 SHALL keep a pending bit per register: set on an accepted load issue with rd != 0; cleared at the clock edge ending the cycle where o_wr_en=1 writes that load's result.
REQ-013 SHALL give set priority when a set and a clear of the same register fall on the same edge.
REQ-014 SHALL make o_stall combinational: pending[rs1] | pending[rs2] | pending[rd], ignoring address 0.
REQ-015 With p_half_regfile=1, SHALL assert o_addr_oob combinationally if bit 4 is set on any valid ALU/issue address or any query address.
REQ-016 With p_half_regfile=1, SHALL discard an out-of-bounds ALU write or load issue (no tag push).
REQ-017 SHALL pulse o_ld_unexp for one cycle on i_ld_valid with an empty tag FIFO and SHALL discard that data.
REQ-018 SHALL never lose a write: every accepted load and every ALU result with rd != 0 yields exactly one o_wr_en pulse.

Reset
REQ-019 SHALL, on i_rst at a clock edge, clear the tag FIFO, hold register, all pending bits and output registers: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_ld_unexp=0.
REQ-020 SHALL discard in-flight loads on reset mid-operation; the LSU is reset by the same i_rst.

Verification
REQ-021 ALU x5=0x1234 at cycle 0 -> o_wr_en=1, addr 5, data 0x1234 in cycle 1 only.
REQ-022 Issue load x7; query rs1=7 -> o_stall=1 until the edge after o_wr_en writes x7, then 0.
REQ-023 Load response and ALU x3 in same cycle -> cycle+1 writes x3; cycle+2 writes the load; o_ld_ready=0 while held.
REQ-024 Issue loads x8, x9 with p_ld_depth=2 -> o_ld_issue_ready=0; a third issue is ignored; responses A, B -> writes x8=A, then x9=B.
REQ-025 i_ld_valid with no load outstanding -> o_ld_unexp=1 for one cycle, no write; load to x0 -> tag popped, no write, no stall.
REQ-026 p_half_regfile=1, ALU rd=17 -> o_addr_oob=1, no write; i_rst with 2 loads outstanding -> o_ld_issue_ready=1, o_stall=0 next cycle.
